// File: rtl/adc_cap_pkg.sv
// Shared defaults and limits for the AD9244 capture path.
package adc_cap_pkg;
   localparam int ADC_W_DEF    = 14;
   localparam int AVG_LOG2_DEF = 2;
   localparam int AVG_LOG2_MIN = 0;
   localparam int AVG_LOG2_MAX = 6;
   localparam int FIFO_AW_DEF  = 4;
   localparam int ACC_W        = ADC_W_DEF + AVG_LOG2_DEF;
   localparam int DEPTH        = 1 << FIFO_AW_DEF;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: dout presents the head whenever empty is low.
module sync_fifo_fwft
   import adc_cap_pkg::*;
#(
   parameter int WIDTH = ADC_W_DEF,
   parameter int AW    = FIFO_AW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [AW:0]      level
);
   localparam int          ENTRIES  = 1 << AW;
   localparam logic [AW:0] FULL_LVL = (AW + 1)'(ENTRIES);

   logic [WIDTH-1:0] mem [ENTRIES];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/adc_w_capture.sv
// AD9244 capture: write-strobe edge detect, 2^AVG_LOG2 boxcar average, show-ahead output FIFO.
// Macro ADC_OTR_CLAMP_EN adds out-of-range clamping (adc_otr input, sticky otr_seen output).
module adc_w_capture
   import adc_cap_pkg::*;
#(
   parameter int ADC_W    = ADC_W_DEF,
   parameter int AVG_LOG2 = AVG_LOG2_DEF,
   parameter int FIFO_AW  = FIFO_AW_DEF
) (
   input  logic               clk_80m,
   input  logic               rst,
   input  logic               clk_W_AD9244,
   input  logic               capture_en,
   input  logic [ADC_W-1:0]   adc_data,
`ifdef ADC_OTR_CLAMP_EN
   input  logic               adc_otr,
   output logic               otr_seen,
`endif
   output logic [ADC_W-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   input  logic               clear_ovf
);
   localparam int               SUM_W    = ADC_W + AVG_LOG2;
   localparam int               CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic               w_d_p0;
   logic               seen_low_p0;
   logic               rise_p0;
   logic [ADC_W-1:0]   sample_p0;
   logic [ADC_W-1:0]   data_p1;
   logic               vld_p1;
   logic [SUM_W-1:0]   acc_p2;
   logic [CNT_W-1:0]   cnt_p2;
   logic [SUM_W-1:0]   sum_p2;
   logic [ADC_W-1:0]   avg_p2;
   logic               push_p2;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;
   logic               drop;

   function automatic logic [ADC_W-1:0] avg_trunc(input logic [SUM_W-1:0] sum);
      return ADC_W'(sum >> AVG_LOG2);
   endfunction

`ifdef ADC_OTR_CLAMP_EN
   function automatic logic [ADC_W-1:0] otr_clamp(input logic [ADC_W-1:0] d, input logic otr);
      if (!otr) return d;
      return d[ADC_W-1] ? '1 : '0;
   endfunction

   assign sample_p0 = otr_clamp(adc_data, adc_otr);
`else
   assign sample_p0 = adc_data;
`endif

   // Stage 0 -> 1: a strobe already high at reset release must drop once before it can count.
   assign rise_p0 = clk_W_AD9244 & ~w_d_p0 & seen_low_p0 & capture_en;

   always_ff @(posedge clk_80m or posedge rst) begin
      if (rst) begin
         w_d_p0      <= 1'b0;
         seen_low_p0 <= 1'b0;
         data_p1     <= '0;
         vld_p1      <= 1'b0;
      end else begin
         w_d_p0 <= clk_W_AD9244;
         if (!clk_W_AD9244) seen_low_p0 <= 1'b1;
         if (rise_p0) data_p1 <= sample_p0;
         vld_p1 <= rise_p0;
      end
   end

   // Stage 1 -> 2: accumulate, emit the truncated mean on the last sample of a block.
   assign sum_p2  = acc_p2 + SUM_W'(data_p1);
   assign avg_p2  = avg_trunc(sum_p2);
   assign push_p2 = vld_p1 & capture_en & (cnt_p2 == CNT_LAST);

   always_ff @(posedge clk_80m or posedge rst) begin
      if (rst) begin
         acc_p2 <= '0;
         cnt_p2 <= '0;
      end else if (!capture_en) begin
         acc_p2 <= '0;
         cnt_p2 <= '0;
      end else if (vld_p1) begin
         if (cnt_p2 == CNT_LAST) begin
            acc_p2 <= '0;
            cnt_p2 <= '0;
         end else begin
            acc_p2 <= sum_p2;
            cnt_p2 <= cnt_p2 + CNT_W'(1);
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH (ADC_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk_80m),
      .rst   (rst),
      .push  (push_p2),
      .din   (avg_p2),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (out_data),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign drop      = push_p2 & fifo_full & ~pop;

   // Sticky flags: a new event in the same cycle as clear_ovf takes priority.
   always_ff @(posedge clk_80m or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clear_ovf) begin
         overflow <= 1'b0;
      end
   end

`ifdef ADC_OTR_CLAMP_EN
   always_ff @(posedge clk_80m or posedge rst) begin
      if (rst) begin
         otr_seen <= 1'b0;
      end else if (rise_p0 & adc_otr) begin
         otr_seen <= 1'b1;
      end else if (clear_ovf) begin
         otr_seen <= 1'b0;
      end
   end
`endif
endmodule

// File: tb/tb_adc_w_capture.sv
// Directed + randomized bench for adc_w_capture against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_adc_w_capture;
   localparam int ADC_W    = 14;
   localparam int AVG_LOG2 = 2;
   localparam int FIFO_AW  = 4;
   localparam int NAVG     = 1 << AVG_LOG2;
   localparam int DEPTH    = 1 << FIFO_AW;
   localparam int FULLSCL  = (1 << ADC_W) - 1;

   logic               clk_80m = 1'b0;
   logic               rst;
   logic               strobe;
   logic               capture_en;
   logic [ADC_W-1:0]   adc_data;
   logic [ADC_W-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [FIFO_AW:0]   fifo_level;
   logic               overflow;
   logic               clear_ovf;
`ifdef ADC_OTR_CLAMP_EN
   logic               adc_otr;
   logic               otr_seen;
`endif

   int passed = 0;
   int total  = 0;
   int mq[$];
   int part[$];
   bit m_ovf = 0;
   bit m_otr = 0;

   always #5 clk_80m = ~clk_80m;

   adc_w_capture #(
      .ADC_W    (ADC_W),
      .AVG_LOG2 (AVG_LOG2),
      .FIFO_AW  (FIFO_AW)
   ) dut (
      .clk_80m      (clk_80m),
      .rst          (rst),
      .clk_W_AD9244 (strobe),
      .capture_en   (capture_en),
      .adc_data     (adc_data),
`ifdef ADC_OTR_CLAMP_EN
      .adc_otr      (adc_otr),
      .otr_seen     (otr_seen),
`endif
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clear_ovf    (clear_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Model: one captured sample; pop/clear act on the same edge that would push its average.
   function automatic void model_step(input int v, input bit otr, input bit pop, input bit clr);
      int val;
      int sum;
      val = v;
      if (capture_en && otr) begin
         val   = (v >= (1 << (ADC_W - 1))) ? FULLSCL : 0;
         m_otr = 1'b1;
      end
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (clr) begin
         m_ovf = 1'b0;
         m_otr = 1'b0;
      end
      if (capture_en) begin
         part.push_back(val);
         if (part.size() == NAVG) begin
            sum = 0;
            foreach (part[i]) sum += part[i];
            part.delete();
            if (mq.size() < DEPTH) mq.push_back(sum / NAVG);
            else m_ovf = 1'b1;
         end
      end
   endfunction

   // One strobe period of 4 cycles: high for two, low for two.
   task automatic sample(input int v, input bit otr, input bit pop, input bit clr);
      @(negedge clk_80m);
      adc_data = ADC_W'(v);
      strobe   = 1'b1;
`ifdef ADC_OTR_CLAMP_EN
      adc_otr  = otr;
`endif
      @(negedge clk_80m);
      out_ready = pop;
      clear_ovf = clr;
      model_step(v, otr, pop, clr);
      @(negedge clk_80m);
      out_ready = 1'b0;
      clear_ovf = 1'b0;
      strobe    = 1'b0;
`ifdef ADC_OTR_CLAMP_EN
      adc_otr   = 1'b0;
`endif
      @(negedge clk_80m);
   endtask

   task automatic check_state(input string tag);
      check({tag, ".valid"}, out_valid, mq.size() > 0);
      check({tag, ".level"}, fifo_level, mq.size());
      check({tag, ".ovf"}, overflow, m_ovf);
      if (mq.size() > 0) check({tag, ".head"}, out_data, mq[0]);
`ifdef ADC_OTR_CLAMP_EN
      check({tag, ".otr"}, otr_seen, m_otr);
`endif
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) begin
         check({tag, ".head"}, out_data, mq[0]);
         out_ready = 1'b1;
         @(negedge clk_80m);
         out_ready = 1'b0;
         void'(mq.pop_front());
      end
      check({tag, ".empty"}, out_valid, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      strobe     = 1'b0;
      capture_en = 1'b1;
      out_ready  = 1'b0;
      clear_ovf  = 1'b0;
      adc_data   = '0;
`ifdef ADC_OTR_CLAMP_EN
      adc_otr    = 1'b0;
`endif
      repeat (3) @(negedge clk_80m);
      check("rst.valid", out_valid, 1'b0);
      check("rst.level", fifo_level, 0);
      check("rst.ovf", overflow, 1'b0);
      check("rst.data", out_data, 0);
      rst = 1'b0;
      @(negedge clk_80m);

      // Basic average and latency
      sample(100, 0, 0, 0);
      sample(200, 0, 0, 0);
      sample(300, 0, 0, 0);
      @(negedge clk_80m);
      adc_data = ADC_W'(400);
      strobe   = 1'b1;
      model_step(400, 0, 0, 0);
      @(negedge clk_80m);
      check("lat.after_e1", out_valid, 1'b0);
      @(negedge clk_80m);
      check("lat.after_e2", out_valid, 1'b1);
      check("lat.avg", out_data, 250);
      strobe = 1'b0;
      @(negedge clk_80m);
      check_state("t1");
      drain("t1");

      // Truncation near full scale
      sample(16383, 0, 0, 0);
      sample(16383, 0, 0, 0);
      sample(16383, 0, 0, 0);
      sample(16382, 0, 0, 0);
      check_state("trunc");
      drain("trunc");

      // Fill past capacity, then push coinciding with pop and clear
      for (int g = 0; g < DEPTH + 1; g++)
         for (int s = 0; s < NAVG; s++) sample(500 * g + 3 * s, 0, 0, 0);
      check("full.level", fifo_level, DEPTH);
      check("full.ovf", overflow, 1'b1);
      check_state("full");
      for (int s = 0; s < NAVG; s++) sample(9000 + s, 0, s == NAVG - 1, s == NAVG - 1);
      check("fullpop.level", fifo_level, DEPTH);
      check("fullpop.ovf", overflow, 1'b0);
      check_state("fullpop");
      drain("full");

      // Partial average discarded by capture_en
      sample(7000, 0, 0, 0);
      sample(7000, 0, 0, 0);
      @(negedge clk_80m);
      capture_en = 1'b0;
      @(negedge clk_80m);
      part.delete();
      capture_en = 1'b1;
      for (int s = 0; s < NAVG; s++) sample(1000, 0, 0, 0);
      check("en.out", out_data, 1000);
      check_state("en");
      drain("en");

      // Randomized run with sporadic pops and clears
      for (int n = 0; n < 120; n++) begin
         sample($urandom_range(0, FULLSCL), 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0);
         check_state("rand");
      end
      drain("rand");

      // Async reset mid-operation
      for (int n = 0; n < 5 * NAVG + 2; n++) sample($urandom_range(0, FULLSCL), 0, 0, 0);
      check_state("prerst");
      @(negedge clk_80m);
      strobe = 1'b1;
      adc_data = '0;
      #2 rst = 1'b1;
      #1;
      check("arst.valid", out_valid, 1'b0);
      check("arst.level", fifo_level, 0);
      check("arst.data", out_data, 0);
      mq.delete();
      part.delete();
      m_ovf = 1'b0;
      m_otr = 1'b0;
      @(negedge clk_80m);
      rst = 1'b0;
      repeat (3) @(negedge clk_80m);
      strobe = 1'b0;
      @(negedge clk_80m);
      for (int s = 0; s < NAVG - 1; s++) sample(4000, 0, 0, 0);
      check("arst.no_early", out_valid, 1'b0);
      sample(4000, 0, 0, 0);
      check("arst.first", out_data, 4000);
      check_state("arst");
      drain("arst");

`ifdef ADC_OTR_CLAMP_EN
      sample(16383, 0, 0, 0);
      sample(8192, 1, 0, 0);
      sample(16383, 0, 0, 0);
      sample(16383, 0, 0, 0);
      check("otr.avg", out_data, FULLSCL);
      check("otr.seen", otr_seen, 1'b1);
      check_state("otr");
      drain("otr");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
